// File: rtl/bus_dma_arbiter.sv
// bus_dma_arbiter
// Shares the 8227 core's 16-bit address / 8-bit data bus with one DMA
// requester. The DMA side steals cycles only while the core is reading,
// by pulling coreReady low; core write cycles are never interrupted.
// The bus mux select is the registered ownership state alone, so bus
// ownership only changes on clock edges.
//
// Optional feature macro: BUS_ARB_BURST_LIMIT_EN
//   defined   -> after MAX_BURST consecutive DMA cycles the arbiter spends
//                one forced core cycle in YIELD before re-arbitrating.
//   undefined -> DMA keeps the bus for as long as dmaRequest stays high.
module bus_dma_arbiter #(
  parameter int MAX_BURST = 8  // 1..255, only meaningful with the burst limit
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       coreReadNotWrite,
  input  logic [7:0] coreAddressHigh,
  input  logic [7:0] coreAddressLow,
  input  logic [7:0] coreDataOutput,
  input  logic       dmaRequest,
  input  logic       dmaReadNotWrite,
  input  logic [15:0] dmaAddress,
  input  logic [7:0] dmaDataOutput,
  output logic       coreReady,
  output logic       dmaGrant,
  output logic [7:0] busAddressHigh,
  output logic [7:0] busAddressLow,
  output logic [7:0] busDataOutput,
  output logic       busReadNotWrite,
  output logic [7:0] burstCount
);

  // Ownership states; legacy-compatible plain constants.
  localparam logic [1:0] ST_CORE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DMA   = 2'd2;
  localparam logic [1:0] ST_YIELD = 2'd3;

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  logic [1:0] stateReg;
  logic [1:0] stateNext;
  logic [7:0] burstCountReg;
  logic [7:0] burstCountNext;
  logic       dmaOwnsBus;
  logic       burstLimitHit;

  assign dmaOwnsBus    = (stateReg == ST_DMA);
  // burstCountReg already includes the current DMA cycle, so reaching the
  // limit here means MAX_BURST cycles have been granted back to back.
  assign burstLimitHit = LIMIT_EN && (burstCountReg >= BURST_LIMIT);

  // Next-state arbitration; a falling request always beats the yield.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_CORE: begin
        if (dmaRequest) begin
          stateNext = coreReadNotWrite ? ST_DMA : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!dmaRequest) begin
          stateNext = ST_CORE;
        end else if (coreReadNotWrite) begin
          stateNext = ST_DMA;
        end
      end
      ST_DMA: begin
        if (!dmaRequest) begin
          stateNext = ST_CORE;
        end else if (burstLimitHit) begin
          stateNext = ST_YIELD;
        end
      end
      ST_YIELD: begin
        stateNext = ST_CORE;
      end
      default: begin
        stateNext = ST_CORE;
      end
    endcase
  end

  // Burst counter counts granted cycles, saturating, cleared outside DMA.
  always_comb begin
    burstCountNext = 8'd0;
    if (stateNext == ST_DMA) begin
      if (burstCountReg == 8'hFF) begin
        burstCountNext = burstCountReg;
      end else begin
        burstCountNext = burstCountReg + 8'd1;
      end
    end
  end

  // Ownership and burst registers; reset releases the bus without a clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateReg      <= ST_CORE;
      burstCountReg <= 8'd0;
    end else begin
      stateReg      <= stateNext;
      burstCountReg <= burstCountNext;
    end
  end

  assign coreReady  = !dmaOwnsBus;
  assign dmaGrant   = dmaOwnsBus;
  assign burstCount = burstCountReg;

  // Bus mux, selected purely by the registered ownership state.
  always_comb begin
    busAddressHigh  = coreAddressHigh;
    busAddressLow   = coreAddressLow;
    busDataOutput   = coreDataOutput;
    busReadNotWrite = coreReadNotWrite;
    if (dmaOwnsBus) begin
      busAddressHigh  = dmaAddress[15:8];
      busAddressLow   = dmaAddress[7:0];
      busDataOutput   = dmaDataOutput;
      busReadNotWrite = dmaReadNotWrite;
    end
  end

endmodule

// File: doc/bus_dma_arbiter.md
# bus_dma_arbiter

Sits between the 8227 core's external bus pins and the board bus. It shares the single 16-bit address / 8-bit data bus between the core and one DMA requester. Bus cycles are stolen only by stalling the core through its ready input, and only on core read cycles, because 8227 write cycles cannot be halted. All bus outputs come from a registered ownership state machine, so ownership changes only on clock edges.

## Interface
Parameters:
- MAX_BURST, default 8: maximum consecutive DMA-owned cycles before a forced core cycle. Only used when the burst-limit macro is defined; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- coreReadNotWrite  in  1  core bus direction; 1 = read.
- coreAddressHigh  in  8  core address bus high byte.
- coreAddressLow  in  8  core address bus low byte.
- coreDataOutput  in  8  core write data.
- dmaRequest  in  1  DMA wants the bus; held high for the whole burst.
- dmaReadNotWrite  in  1  DMA transfer direction; 1 = read.
- dmaAddress  in  16  DMA address.
- dmaDataOutput  in  8  DMA write data.
- coreReady  out  1  to core ready input; 0 stalls the core and it repeats its current read.
- dmaGrant  out  1  DMA owns the bus this cycle; one transfer per cycle while high.
- busAddressHigh  out  8  muxed address high byte.
- busAddressLow  out  8  muxed address low byte.
- busDataOutput  out  8  muxed write data.
- busReadNotWrite  out  1  muxed direction.
- burstCount  out  8  DMA cycles granted in the current burst; saturates at 255.

## Operation
States: CORE, WAIT, DMA, YIELD. YIELD is reachable only with the burst-limit macro defined.

- **CORE**: coreReady=1, dmaGrant=0, bus driven by core.
  - dmaRequest=1 and coreReadNotWrite=1: go to DMA.
  - dmaRequest=1 and coreReadNotWrite=0: go to WAIT.
- **WAIT**: same outputs as CORE.
  - dmaRequest=0: go to CORE.
  - else, if coreReadNotWrite=1: go to DMA.
  - Covers back-to-back core writes, e.g. 3 pushes during an interrupt sequence.
- **DMA**: coreReady=0, dmaGrant=1, bus driven from dmaAddress, dmaDataOutput and dmaReadNotWrite. burstCount increments on every DMA cycle.
  - dmaRequest=0: go to CORE. burstCount clears on entry to CORE.
  - Burst limit reached: go to YIELD.
- **YIELD**: exactly one cycle with CORE outputs; burstCount clears.
  - Then go to CORE.
  - A still-high dmaRequest is re-arbitrated from CORE on the next cycle.

Mux and priority rules:
- Bus mux select is the registered state only. No combinational path runs from dmaRequest to the bus outputs.
- If dmaRequest falls in the same cycle the burst limit is reached, the exit to CORE wins over YIELD.
- burstCount saturates at 255 and does not wrap.
- Once dmaGrant=1, the DMA side is responsible for keeping dmaAddress stable for that cycle.

## Timing
- Reset (nrst low, asynchronous):
  - State = CORE, coreReady=1, dmaGrant=0, burstCount=0.
  - Bus outputs mirror the core inputs.
  - Reset during DMA releases the bus immediately, without waiting for a clock.
- Grant latency:
  - dmaRequest seen high at edge N while the core is reading: dmaGrant=1 and coreReady=0 from edge N+1.
  - If the core is writing, the grant follows one cycle after the first core read cycle.
- Release latency: dmaRequest low at edge N gives dmaGrant=0 and coreReady=1 from edge N+1. Exactly one core cycle is lost per re-entry.
- The core's in-flight read completes normally at the edge where DMA is entered, then the core is stalled.

## Configuration
- Macro BUS_ARB_BURST_LIMIT_EN.
- Defined:
  - After MAX_BURST consecutive DMA cycles the arbiter enters YIELD for one forced core cycle.
  - With a continuous request, dmaGrant pattern is MAX_BURST high, then 2 low (YIELD + CORE), repeating.
- Undefined:
  - YIELD state and MAX_BURST are unused.
  - DMA holds the bus for as long as dmaRequest stays high.

## Test plan
- **Reset mid-burst**: assert nrst=0 while in DMA -> dmaGrant=0, coreReady=1, burstCount=0 immediately, before any clock edge; bus shows the core address.
- **Simple steal**: core reading 0x1234, dmaRequest=1 with dmaAddress=0xC000 for 3 cycles -> coreReady low for exactly 3 cycles, bus address 0xC000 during them, burstCount reaches 3, core resumes at 0x1234.
- **Write deferral**: dmaRequest rises during 3 consecutive core writes (rNW=0) -> no grant until the first read, then dmaGrant=1 one cycle later; busReadNotWrite never driven by DMA during the core writes.
- **Request drop in WAIT**: dmaRequest pulses for 1 cycle during a core write -> returns to CORE with dmaGrant never asserted.
- **Burst limit** (macro defined, MAX_BURST=4): continuous dmaRequest for 20 cycles -> dmaGrant pattern 4 on / 2 off, repeating; with the macro undefined, dmaGrant stays high for all 20.
- **Simultaneous events** (macro defined): dmaRequest falls in the 4th DMA cycle with MAX_BURST=4 -> next state CORE (not YIELD); regrant possible on the following cycle.
